apb_slave_regs: RTL

- APB2 responder: a 32-bit register bank with an optional compare timer and interrupt.
- Sits on one `pselx` slot of the AHB-to-APB bridge:
  - Receives `psel`, `penable`, `pwrite`, `paddr` and `pwdata`.
  - Returns `prdata`.
- Tracks the APB phase sequence with a three-state FSM and flags protocol violations in a status register.
- Runs on the bridge clock; there is no `pready` (zero wait states).

---
 rtl/apb_slave_regs_if.sv | 15 +
 rtl/apb_slave_regs.sv | 127 ++++++++++++
 2 files changed

// File: rtl/apb_slave_regs_if.sv
// APB2 slot bundle between the AHB-to-APB bridge and one register-bank responder.
interface apb_slave_regs_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_slave_regs.sv
// APB2 register bank with phase-tracking FSM and protocol-error status.
// Compare timer and interrupt are present only when APB_SLV_TIMER_EN is defined.
module apb_slave_regs #(
    parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic              hclk,
    input  logic              hresetn,
    apb_slave_regs_if.slave   apb,
    output logic              irq
);
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t          state_q, state_nxt;
    logic            commit_c, err_set_c, rd_load_c;
    logic [2:0]      idx_c;
    logic            wr_c;
    logic [1:0]      w1c_c;
    logic            hw_set_c;
    logic [DW-1:0]   rdata_c;

    logic            timer_en_q, irq_en_q;
    logic            irq_pending_q, prot_err_q;
    logic [DW-1:0]   scratch0_q, scratch1_q;
    logic [DW-1:0]   timer_q, compare_q;
    logic [DW-1:0]   prdata_q;
    logic            irq_q;

    logic            unused_paddr;
    assign unused_paddr = ^{apb.paddr[31:5], apb.paddr[1:0]};

    assign idx_c = apb.paddr[4:2];

    // Phase tracker: state register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= S_IDLE;
        else          state_q <= state_nxt;
    end

    // Phase tracker: next state, commit strobe and violation detection
    always_comb begin
        state_nxt = S_IDLE;
        commit_c  = 1'b0;
        err_set_c = 1'b0;
        if (apb.psel && !apb.penable) begin
            state_nxt = S_SETUP;
            err_set_c = (state_q == S_SETUP);
        end else if (apb.psel && apb.penable) begin
            if (state_q == S_SETUP) begin
                state_nxt = S_ACCESS;
                commit_c  = 1'b1;
            end else begin
                err_set_c = 1'b1;
            end
        end else begin
            err_set_c = (state_q == S_SETUP);
        end
    end

    assign rd_load_c = apb.psel && !apb.penable && !apb.pwrite;
    assign wr_c      = commit_c && apb.pwrite;
    assign w1c_c     = (wr_c && idx_c == 3'd1) ? apb.pwdata[1:0] : 2'b00;

    always_comb begin
        rdata_c = '0;
        case (idx_c)
            3'd0:    rdata_c = {30'b0, irq_en_q, timer_en_q};
            3'd1:    rdata_c = {30'b0, prot_err_q, irq_pending_q};
            3'd2:    rdata_c = scratch0_q;
            3'd3:    rdata_c = scratch1_q;
            3'd4:    rdata_c = timer_q;
            3'd5:    rdata_c = compare_q;
            3'd6:    rdata_c = ID_VALUE;
            default: rdata_c = '0;
        endcase
    end

`ifdef APB_SLV_TIMER_EN
    // Free-running compare timer; the match edge wraps to 0 and raises irq_pending
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            timer_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
        end else begin
            if (wr_c && idx_c == 3'd5) compare_q <= apb.pwdata;
            if (timer_en_q) timer_q <= (timer_q == compare_q) ? '0 : timer_q + DW'(1);
        end
    end

    assign hw_set_c = timer_en_q && (timer_q == compare_q);
`else
    assign timer_q   = '0;
    assign compare_q = '0;
    assign hw_set_c  = 1'b0;
`endif

    // Register bank, W1C status (hardware set wins) and registered outputs
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            timer_en_q    <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            prot_err_q    <= 1'b0;
            scratch0_q    <= '0;
            scratch1_q    <= '0;
            prdata_q      <= '0;
            irq_q         <= 1'b0;
        end else begin
            if (wr_c) begin
                case (idx_c)
                    3'd0: {irq_en_q, timer_en_q} <= apb.pwdata[1:0];
                    3'd2: scratch0_q <= apb.pwdata;
                    3'd3: scratch1_q <= apb.pwdata;
                    default: ;
                endcase
            end
            irq_pending_q <= (irq_pending_q & ~w1c_c[0]) | hw_set_c;
            prot_err_q    <= (prot_err_q & ~w1c_c[1]) | err_set_c;
            prdata_q      <= rd_load_c ? rdata_c : '0;
            irq_q         <= irq_pending_q & irq_en_q;
        end
    end

    assign apb.prdata = prdata_q;
    assign irq        = irq_q;
endmodule
